// File: rtl/axis_tok_pkg.sv
// Shared types and ASCII constants for the numeric tokenizer.
// Imported by the interface, the top and the bench.
package axis_tok_pkg;

    typedef enum logic [1:0] {
        NUM = 2'd0,
        SYM = 2'd1,
        EOL = 2'd2
    } tok_kind_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PEND_SYM = 2'd1,
        PEND_EOL = 2'd2
    } tok_state_t;

    localparam logic [7:0] ZERO    = 8'h30;
    localparam logic [7:0] NINE    = 8'h39;
    localparam logic [7:0] DOT     = 8'h2E;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] MAX_COL = 8'd255;

endpackage

// File: rtl/axis_num_tokenizer_if.sv
// Byte-in / token-out stream bundle for axis_num_tokenizer, plus the FSM debug view.
// slave = tokenizer side, master = source/sink side.
interface axis_num_tokenizer_if;
    import axis_tok_pkg::*;

    // Both streams: a beat transfers on a rising edge where valid && ready; the
    // sender holds valid and payload stable until then, ready may change freely.
    logic        tvalid_rx;
    logic        tready_rx;
    logic [7:0]  tdata_rx;
    logic        tlast_rx;

    logic        tvalid_tx;
    logic        tready_tx;
    logic [31:0] tdata_tx;
    logic [1:0]  tkind_tx;
    logic [7:0]  tcol_tx;
    logic        tlast_tx;

    tok_state_t  dbg_state;

    modport slave (
        input  tvalid_rx, tdata_rx, tlast_rx, tready_tx,
        output tready_rx, tvalid_tx, tdata_tx, tkind_tx, tcol_tx, tlast_tx, dbg_state
    );

    modport master (
        output tvalid_rx, tdata_rx, tlast_rx, tready_tx,
        input  tready_rx, tvalid_tx, tdata_tx, tkind_tx, tcol_tx, tlast_tx, dbg_state
    );

endinterface

// File: rtl/tok_dec_acc.sv
// Saturating decimal accumulator: acc <= min(acc*10 + digit, 0xFFFFFFFF).
// clr has priority over load; acc_next exposes the would-be value combinationally.
module tok_dec_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [3:0]  digit,
    output logic [31:0] acc,
    output logic [31:0] acc_next
);

    logic [35:0] prod;

    // 36 bits hold 0xFFFFFFFF*10+9 without overflow, so the top nibble flags saturation.
    assign prod     = ({4'd0, acc} * 36'd10) + {32'd0, digit};
    assign acc_next = (|prod[35:32]) ? 32'hFFFF_FFFF : prod[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 32'd0;
        end else if (clr) begin
            acc <= 32'd0;
        end else if (load) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/axis_num_tokenizer.sv
// ASCII line tokenizer: emits NUM / SYM / EOL tokens from a byte stream.
// Optional macro AXIS_TOK_SYM_EN turns symbol bytes into SYM tokens.
module axis_num_tokenizer
    import axis_tok_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    axis_num_tokenizer_if.slave bus
);

    tok_state_t  state, state_nx;
    logic [7:0]  col, col_inc, num_col, eol_len;
    logic        num_active, pend_eol;
    logic [31:0] acc, acc_next;

    logic        out_vld;
    logic [31:0] out_data;
    tok_kind_t   out_kind;
    logic [7:0]  out_col;

    logic        ld;
    logic [31:0] ld_data;
    tok_kind_t   ld_kind;
    logic [7:0]  ld_col;

    logic        byte_acc, out_take, is_digit, is_sep, is_sym, emit_num;
    logic [7:0]  b;

`ifdef AXIS_TOK_SYM_EN
    logic [7:0]  sym_byte, sym_col;
`endif

    assign b             = bus.tdata_rx;
    assign out_take      = out_vld && bus.tready_tx;
    assign bus.tready_rx = rst && (state == SCAN) && (!out_vld || bus.tready_tx);
    assign byte_acc      = bus.tvalid_rx && bus.tready_rx;

    assign col_inc  = (col == MAX_COL) ? MAX_COL : col + 8'd1;
    assign is_digit = (b >= ZERO) && (b <= NINE);
    assign is_sep   = (b == DOT) || (b == SPACE) || (b == LF) || (b == CR);
`ifdef AXIS_TOK_SYM_EN
    assign is_sym   = !is_digit && !is_sep;
`else
    assign is_sym   = 1'b0;
`endif
    // A digit carrying tlast closes its own number, so NUM then EOL follow.
    assign emit_num = (num_active && !is_digit) || (is_digit && bus.tlast_rx);

    tok_dec_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (byte_acc && emit_num),
        .load     (byte_acc && is_digit && !emit_num),
        .digit    (b[3:0]),
        .acc      (acc),
        .acc_next (acc_next)
    );

    always_comb begin
        ld       = 1'b0;
        ld_data  = 32'd0;
        ld_kind  = NUM;
        ld_col   = 8'd0;
        state_nx = state;
        case (state)
            SCAN: begin
                if (byte_acc) begin
                    if (emit_num) begin
                        ld       = 1'b1;
                        ld_kind  = NUM;
                        ld_data  = is_digit ? acc_next : acc;
                        ld_col   = num_active ? num_col : col;
                        state_nx = is_sym ? PEND_SYM : (bus.tlast_rx ? PEND_EOL : SCAN);
                    end else if (is_sym) begin
                        ld       = 1'b1;
                        ld_kind  = SYM;
                        ld_data  = {24'd0, b};
                        ld_col   = col;
                        state_nx = bus.tlast_rx ? PEND_EOL : SCAN;
                    end else if (bus.tlast_rx) begin
                        ld       = 1'b1;
                        ld_kind  = EOL;
                        ld_col   = col_inc;
                    end
                end
            end
`ifdef AXIS_TOK_SYM_EN
            PEND_SYM: begin
                if (out_take) begin
                    ld       = 1'b1;
                    ld_kind  = SYM;
                    ld_data  = {24'd0, sym_byte};
                    ld_col   = sym_col;
                    state_nx = pend_eol ? PEND_EOL : SCAN;
                end
            end
`endif
            PEND_EOL: begin
                if (out_take) begin
                    ld       = 1'b1;
                    ld_kind  = EOL;
                    ld_col   = eol_len;
                    state_nx = SCAN;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCAN;
            col        <= 8'd0;
            num_active <= 1'b0;
            num_col    <= 8'd0;
            pend_eol   <= 1'b0;
            eol_len    <= 8'd0;
            out_vld    <= 1'b0;
            out_data   <= 32'd0;
            out_kind   <= NUM;
            out_col    <= 8'd0;
        end else begin
            state <= state_nx;
            if (ld) begin
                out_vld  <= 1'b1;
                out_data <= ld_data;
                out_kind <= ld_kind;
                out_col  <= ld_col;
            end else if (out_take) begin
                out_vld  <= 1'b0;
            end
            if (byte_acc) begin
                col        <= bus.tlast_rx ? 8'd0 : col_inc;
                num_active <= is_digit && !emit_num;
                if (is_digit && !num_active) num_col <= col;
                pend_eol   <= bus.tlast_rx;
                eol_len    <= col_inc;
            end
        end
    end

`ifdef AXIS_TOK_SYM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_byte <= 8'd0;
            sym_col  <= 8'd0;
        end else if (byte_acc) begin
            sym_byte <= b;
            sym_col  <= col;
        end
    end
`endif

    assign bus.tvalid_tx = out_vld;
    assign bus.tdata_tx  = out_data;
    assign bus.tkind_tx  = out_kind;
    assign bus.tcol_tx   = out_col;
    assign bus.tlast_tx  = (out_kind == EOL);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_axis_num_tokenizer.sv
// Self-checking bench for axis_num_tokenizer (honours AXIS_TOK_SYM_EN when defined).
// Directed scenarios use hand-derived tokens; random traffic uses a line-level model.
module tb_axis_num_tokenizer;
    import axis_tok_pkg::*;

    localparam logic [1:0] KN = 2'd0, KS = 2'd1, KE = 2'd2;
`ifdef AXIS_TOK_SYM_EN
    localparam bit SYM_EN = 1'b1;
`else
    localparam bit SYM_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_num_tokenizer_if bus ();
    axis_num_tokenizer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [42:0] exp_q[$];
    logic [42:0] obs_q[$];

    // tready_tx source: 0 = always ready, 1 = random, 2 = forced by the running test
    int   rdy_mode  = 0;
    logic rdy_force = 1'b0;
    logic rdy_rand  = 1'b1;
    assign bus.tready_tx = (rdy_mode == 1) ? rdy_rand : ((rdy_mode == 2) ? rdy_force : 1'b1);
    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst && bus.tvalid_tx && bus.tready_tx)
            obs_q.push_back({bus.tkind_tx, bus.tdata_tx, bus.tcol_tx, bus.tlast_tx});
    end

    // reference model state
    int     m_col   = 0;
    bit     m_num   = 1'b0;
    int     m_start = 0;
    longint m_val   = 0;

    function automatic logic [42:0] tok(input logic [1:0] k, input logic [31:0] d, input logic [7:0] c);
        return {k, d, c, (k == KE)};
    endfunction

    function automatic void model_reset();
        m_col = 0;
        m_num = 1'b0;
        m_val = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit last);
        bit dig, sep;
        dig = (b >= 8'h30) && (b <= 8'h39);
        sep = (b == 8'h2E) || (b == 8'h20) || (b == 8'h0A) || (b == 8'h0D);
        if (dig) begin
            if (!m_num) begin
                m_num   = 1'b1;
                m_start = m_col;
                m_val   = 0;
            end
            m_val = m_val * 10 + longint'(b - 8'h30);
            if (m_val > 64'hFFFF_FFFF) m_val = 64'hFFFF_FFFF;
        end
        if (m_num && (!dig || last)) begin
            exp_q.push_back(tok(KN, m_val[31:0], m_start[7:0]));
            m_num = 1'b0;
        end
        if (!dig && !sep && SYM_EN)
            exp_q.push_back(tok(KS, {24'd0, b}, m_col[7:0]));
        m_col = (m_col < 255) ? m_col + 1 : 255;
        if (last) begin
            exp_q.push_back(tok(KE, 32'd0, m_col[7:0]));
            m_col = 0;
        end
    endfunction

    function automatic logic [7:0] pick_byte(input bit digits_only);
        if (digits_only) return 8'h30 + 8'($urandom_range(0, 9));
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 8'h30 + 8'($urandom_range(0, 9));
            5:       return 8'h2E;
            6:       return 8'h20;
            7:       return ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
            default: return ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h61;
        endcase
    endfunction

    // driver tasks: entered and left at posedge+1
    task automatic send_byte(input logic [7:0] b, input bit last);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        bus.tvalid_rx = 1'b1;
        bus.tdata_rx  = b;
        bus.tlast_rx  = last;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = bus.tready_rx;
            @(posedge clk);
            #1;
            n++;
        end
        bus.tvalid_rx = 1'b0;
        bus.tlast_rx  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout byte=%h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic send_str(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_at_end && (i == s.len() - 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.tvalid_rx = 1'b1;
        bus.tdata_rx  = 8'h35;
        bus.tlast_rx  = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.tvalid_tx !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", bus.tvalid_tx); end
        checks++;
        if (bus.tdata_tx !== 32'd0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", bus.tdata_tx); end
        checks++;
        if (bus.tkind_tx !== 2'd0) begin failures++; $display("FAIL rst_tkind got=%0d exp=0", bus.tkind_tx); end
        checks++;
        if (bus.tcol_tx !== 8'd0) begin failures++; $display("FAIL rst_tcol got=%0d exp=0", bus.tcol_tx); end
        checks++;
        if (bus.tlast_tx !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", bus.tlast_tx); end
        checks++;
        if (bus.tready_rx !== 1'b0) begin failures++; $display("FAIL rst_tready_rx got=%b exp=0", bus.tready_rx); end
        bus.tvalid_rx = 1'b0;
        bus.tlast_rx  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.tready_rx !== 1'b1) begin failures++; $display("FAIL rel_tready_rx got=%b exp=1", bus.tready_rx); end
        checks++;
        if (bus.dbg_state !== SCAN) begin failures++; $display("FAIL rel_state got=%0d exp=%0d", bus.dbg_state, SCAN); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lines();
        logic [42:0] e, o;
        rdy_mode = 0;
        exp_q.push_back(tok(KN, 32'd467, 8'd0));
        exp_q.push_back(tok(KN, 32'd114, 8'd5));
        exp_q.push_back(tok(KE, 32'd0, 8'd8));
        send_str("467..114", 1'b1);
        exp_q.push_back(tok(KN, 32'd12, 8'd0));
        if (SYM_EN) exp_q.push_back(tok(KS, 32'h2A, 8'd2));
        exp_q.push_back(tok(KN, 32'd3, 8'd3));
        exp_q.push_back(tok(KE, 32'd0, 8'd4));
        send_str("12*3", 1'b1);
        exp_q.push_back(tok(KN, 32'hFFFF_FFFF, 8'd0));
        exp_q.push_back(tok(KE, 32'd0, 8'd12));
        send_str("4294967296 ", 1'b0);
        send_byte(8'h0A, 1'b1);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL lines_tok missing exp kind=%0d data=%h col=%0d last=%b", e[42:41], e[40:9], e[8:1], e[0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL lines_tok got kind=%0d data=%h col=%0d last=%b exp kind=%0d data=%h col=%0d last=%b",
                             o[42:41], o[40:9], o[8:1], o[0], e[42:41], e[40:9], e[8:1], e[0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL lines_extra got %0d extra tokens exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_stall();
        logic [42:0] st[$];
        logic [42:0] e, o, cur;
        st.push_back(tok(KN, 32'd7, 8'd0));
        if (SYM_EN) st.push_back(tok(KS, 32'h23, 8'd1));
        st.push_back(tok(KE, 32'd0, 8'd2));
        foreach (st[k]) exp_q.push_back(st[k]);
        rdy_force = 1'b0;
        rdy_mode  = 2;
        send_byte(8'h37, 1'b0);
        send_byte(8'h23, 1'b1);
        foreach (st[k]) begin
            repeat (5) begin
                @(negedge clk);
                cur = {bus.tkind_tx, bus.tdata_tx, bus.tcol_tx, bus.tlast_tx};
                checks++;
                if (bus.tvalid_tx !== 1'b1 || cur !== st[k]) begin
                    failures++;
                    $display("FAIL stall_hold got vld=%b tok=%h exp vld=1 tok=%h", bus.tvalid_tx, cur, st[k]);
                end
                checks++;
                if (bus.tready_rx !== 1'b0) begin failures++; $display("FAIL stall_tready_rx got=%b exp=0", bus.tready_rx); end
            end
            @(posedge clk);
            #1;
            rdy_force = 1'b1;
            @(posedge clk);
            #1;
            rdy_force = 1'b0;
        end
        rdy_mode = 0;
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL stall_tok missing exp kind=%0d data=%h col=%0d", e[42:41], e[40:9], e[8:1]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL stall_tok got %h exp %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL stall_extra got %0d extra tokens exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        logic [42:0] e, o;
        rdy_force = 1'b0;
        rdy_mode  = 2;
        send_byte(8'h39, 1'b0);
        send_byte(8'h38, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.tvalid_tx !== 1'b0) begin failures++; $display("FAIL midrst_tvalid got=%b exp=0", bus.tvalid_tx); end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rdy_mode = 0;
        model_reset();
        exp_q.push_back(tok(KN, 32'd5, 8'd0));
        exp_q.push_back(tok(KE, 32'd0, 8'd1));
        send_byte(8'h35, 1'b1);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL midrst_tok missing exp kind=%0d data=%h col=%0d", e[42:41], e[40:9], e[8:1]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL midrst_tok got %h exp %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_extra got %0d extra tokens exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_long_line();
        logic [42:0] e, o;
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            model_byte(8'h61, i == 299);
            send_byte(8'h61, i == 299);
        end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL long_tok missing exp kind=%0d col=%0d", e[42:41], e[8:1]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL long_tok got %h exp %h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL long_extra got %0d extra tokens exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_random();
        logic [42:0] e, o;
        logic [7:0]  c;
        int          len;
        bit          do_last, last, digits_only;
        rdy_mode = 1;
        for (int l = 0; l < 40; l++) begin
            len         = $urandom_range(1, 12);
            digits_only = (l % 6 == 0);
            do_last     = ($urandom_range(0, 4) != 0) || (l == 39);
            for (int i = 0; i < len; i++) begin
                c    = pick_byte(digits_only);
                last = do_last && (i == len - 1);
                model_byte(c, last);
                send_byte(c, last);
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        rdy_mode = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL rand_tok missing exp kind=%0d data=%h col=%0d", e[42:41], e[40:9], e[8:1]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL rand_tok got kind=%0d data=%h col=%0d last=%b exp kind=%0d data=%h col=%0d last=%b",
                             o[42:41], o[40:9], o[8:1], o[0], e[42:41], e[40:9], e[8:1], e[0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rand_extra got %0d extra tokens exp 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        bus.tvalid_rx = 1'b0;
        bus.tdata_rx  = 8'd0;
        bus.tlast_rx  = 1'b0;
        test_reset();
        test_lines();
        test_stall();
        test_reset_mid();
        test_long_line();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
